// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and constants for the bit-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

   // Largest supported operand width
   localparam int MAX_WIDTH = 64;

   // Control states of the serial adder
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder / full_adder
//  Description : One-bit adder slice built from two half adders and an OR
//                of their carries.
//  Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic w_s1;
   logic w_c1;
   logic w_c2;

   half_adder u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (w_s1),
      .carry (w_c1)
   );

   half_adder u_ha1 (
      .a     (w_s1),
      .b     (cin),
      .sum   (sum),
      .carry (w_c2)
   );

   // At most one half adder can generate a carry, so OR is sufficient
   assign cout = w_c1 | w_c2;
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder, LSB first, one bit per clock through a
//                single full-adder slice. Valid/ready on input and output.
//                Define SERIAL_ADDER_OVERFLOW_EN to add the signed overflow
//                output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);
   import serial_adder_pkg::*;

   localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic [WIDTH-1:0]   r_sum;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_c;
   logic               r_carry;
   logic               w_s;
   logic               w_cout;
   logic               w_last;
   logic [WIDTH-1:0]   w_sum_next;

   full_adder u_fa (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .cin  (r_c),
      .sum  (w_s),
      .cout (w_cout)
   );

   // Sum shift register with the new bit entering at the MSB
   if (WIDTH == 1) begin : g_sum_w1
      logic [WIDTH-1:0] w_unused_sum_sh;
      assign w_unused_sum_sh = r_sum_sh;
      assign w_sum_next      = w_s;
   end else begin : g_sum_wn
      logic w_unused_sum_lsb;
      assign w_unused_sum_lsb = r_sum_sh[0];
      assign w_sum_next       = {w_s, r_sum_sh[WIDTH-1:1]};
   end

   assign w_last    = (r_cnt == c_last);
   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign carry     = r_carry;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_next = RUN;
         RUN:     if (w_last)    w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Operand load, serial add, and result capture on the final bit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_c      <= 1'b0;
         r_carry  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_sum_sh <= '0;
                  r_cnt    <= '0;
                  r_c      <= 1'b0;
               end
            end
            RUN: begin
               r_sum_sh <= w_sum_next;
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_c      <= w_cout;
               r_cnt    <= r_cnt + c_cnt_w'(1);
               if (w_last) begin
                  r_sum   <= w_sum_next;
                  r_carry <= w_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic r_overflow;

   // Signed overflow: carry into the MSB differs from carry out of it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if ((r_state == RUN) && w_last) begin
         r_overflow <= r_c ^ w_cout;
      end
   end

   assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic             overflow;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
      logic             c;
      logic             v;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             v;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ,
      .overflow  (overflow)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      exp_t e;
      logic [WIDTH:0] full;
      full = {1'b0, x} + {1'b0, y};
      e.s  = full[WIDTH-1:0];
      e.c  = full[WIDTH];
      e.v  = (x[WIDTH-1] == y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
      return e;
   endfunction

   // Scoreboard: compare each delivered result with the oldest expectation
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_out_valid actual=%0h required=0", out_valid);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_sum", 64'(sum), 64'(mon_e.s));
            chk("sb_carry", 64'(carry), 64'(mon_e.c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
            chk("sb_overflow", 64'(overflow), 64'(mon_e.v));
`endif
         end
      end
   end

   // Present operands, push expectation, complete the accept handshake
   task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input exp_t e);
      int n;
      n        = 0;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=%0d required<50", n);
      end
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
      chk("in_ready_after_accept", 64'(in_ready), 64'd0);
   endtask

   // Count edges from the accept edge until out_valid is seen
   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL out_valid_timeout actual=%0d required<100", n);
      end
   endtask

   vec_t vt[9];
   int   lat;
   logic ov_seen;
   exp_t e;

   initial begin
      vt[0] = '{8'h03, 8'h05, 8'h08, 1'b0, 1'b0};
      vt[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vt[3] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vt[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
      vt[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
      vt[7] = '{8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0};
      vt[8] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};

      // Reset with in_valid asserted: nothing accepted, outputs at reset values
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      a         = 8'hFF;
      b         = 8'hFF;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_in_ready", 64'(in_ready), 64'd1);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_sum", 64'(sum), 64'd0);
         chk("rst_carry", 64'(carry), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
         chk("rst_overflow", 64'(overflow), 64'd0);
`endif
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Table-driven operations with latency check
      for (int i = 0; i < 9; i++) begin
         out_ready = 1'b1;
         e.s = vt[i].s;
         e.c = vt[i].c;
         e.v = vt[i].v;
         start_op(vt[i].a, vt[i].b, e);
         wait_out(lat);
         chk("latency", 64'(lat), 64'(WIDTH));
         tick();
         chk("idle_after_done", 64'(in_ready), 64'd1);
         chk("out_valid_drop", 64'(out_valid), 64'd0);
      end

      // Random operands against the arithmetic model
      for (int i = 0; i < 6; i++) begin
         logic [WIDTH-1:0] x, y;
         x = WIDTH'($urandom);
         y = WIDTH'($urandom);
         out_ready = 1'b1;
         start_op(x, y, model(x, y));
         wait_out(lat);
         tick();
      end

      // Backpressure in DONE while new operands are offered
      out_ready = 1'b0;
      start_op(8'h12, 8'h34, model(8'h12, 8'h34));
      wait_out(lat);
      chk("bp_latency", 64'(lat), 64'(WIDTH));
      a        = 8'h01;
      b        = 8'h02;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_sum_stable", 64'(sum), 64'h46);
         chk("bp_carry_stable", 64'(carry), 64'd0);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
      chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
      sb.push_back(model(8'h01, 8'h02));
      tick();
      in_valid = 1'b0;
      chk("bp_new_accepted", 64'(in_ready), 64'd0);
      wait_out(lat);
      chk("bp_new_latency", 64'(lat), 64'(WIDTH));
      tick();

      // Reset during RUN cycle 4: the operation is discarded
      out_ready = 1'b1;
      start_op(8'hAA, 8'h55, model(8'hAA, 8'h55));
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
      chk("midrun_rst_sum", 64'(sum), 64'd0);
      ov_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) ov_seen = 1'b1;
         tick();
      end
      chk("midrun_no_out_valid", 64'(ov_seen), 64'd0);
      chk("midrun_idle", 64'(in_ready), 64'd1);
      start_op(8'h10, 8'h20, '{8'h30, 1'b0, 1'b0});
      wait_out(lat);
      chk("post_rst_latency", 64'(lat), 64'(WIDTH));
      tick();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
